// File: rtl/wb_bfm_slave.sv
// Wishbone slave BFM: turns Wishbone beats into a req/resp handshake on the user side.
// Define WB_BFM_SLAVE_ADDR_CHECK_EN to check the master's burst addresses against the computed ones.

module wb_bfm_lane (
   input  logic       wb_clk,
   input  logic       wb_rst_n,
   input  logic       ld_w,
   input  logic       ld_r,
   input  logic [7:0] wdat,
   input  logic       wsel,
   input  logic [7:0] rdat,
   output logic [7:0] wdata_q,
   output logic       mask_q,
   output logic [7:0] rdata_q
);

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         wdata_q <= '0;
         mask_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (ld_w) begin
            wdata_q <= wdat;
            mask_q  <= wsel;
         end
         if (ld_r) rdata_q <= rdat;
      end
   end

endmodule

module wb_bfm_slave #(
   parameter int aw = 32,
   parameter int dw = 32
) (
   input  logic            wb_clk,
   input  logic            wb_rst_n,
   input  logic [aw-1:0]   wb_adr_i,
   input  logic [dw-1:0]   wb_dat_i,
   input  logic [dw/8-1:0] wb_sel_i,
   input  logic            wb_we_i,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic [2:0]      wb_cti_i,
   input  logic [1:0]      wb_bte_i,
   output logic [dw-1:0]   wb_sdt_o,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic            wb_rty_o,
   output logic            req_o,
   output logic            op_o,
   output logic [aw-1:0]   addr_o,
   output logic [dw-1:0]   wdata_o,
   output logic [dw/8-1:0] mask_o,
   output logic            burst_o,
   output logic [1:0]      bte_o,
   output logic            last_o,
   input  logic            rsp_ack_i,
   input  logic            rsp_err_i,
   input  logic [dw-1:0]   rsp_rdata_i,
   output logic [31:0]     rd_cnt_o,
   output logic [31:0]     wr_cnt_o
);

   localparam int NUM_LANES = dw / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state;
   logic          cyc_stb, start, cont, adr_bad, rsp_any;
   logic          ld_w, ld_r, cti_burst, cti_last;
   logic [aw-1:0] inc_addr, wrap_mask, next_addr;

   logic [NUM_LANES-1:0][7:0] wdat_l, rdat_l, wdata_l, rdata_l;
   logic [NUM_LANES-1:0]      mask_l;

   assign cyc_stb   = wb_cyc_i & wb_stb_i;
   assign rsp_any   = rsp_ack_i | rsp_err_i;
   assign cti_burst = (wb_cti_i == 3'b001) | (wb_cti_i == 3'b010);
   assign cti_last  = (wb_cti_i == 3'b000) | (wb_cti_i == 3'b111);

   assign start = (state == S_IDLE) & cyc_stb;
   // RESP with no termination pending is the gap between burst beats; the
   // master only presents the next beat after it has seen the ack.
   assign cont  = (state == S_RESP) & cyc_stb & ~wb_ack_o & ~wb_err_o & ~adr_bad;
   assign ld_w  = start | cont;
   assign ld_r  = (state == S_REQ) & wb_cyc_i & rsp_any & ~op_o;

   assign req_o    = (state == S_REQ);
   assign wb_rty_o = 1'b0;

   always_comb begin
      wrap_mask = '0;
      case (bte_o)
         2'b01:   wrap_mask = aw'(4 * NUM_LANES - 1);
         2'b10:   wrap_mask = aw'(8 * NUM_LANES - 1);
         2'b11:   wrap_mask = aw'(16 * NUM_LANES - 1);
         default: wrap_mask = '0;
      endcase
      inc_addr  = addr_o + aw'(NUM_LANES);
      next_addr = (bte_o == 2'b00) ? inc_addr
                                   : ((addr_o & ~wrap_mask) | (inc_addr & wrap_mask));
   end

`ifdef WB_BFM_SLAVE_ADDR_CHECK_EN
   assign adr_bad = (state == S_RESP) & cyc_stb & ~wb_ack_o & ~wb_err_o
                    & (wb_adr_i != next_addr);
`else
   assign adr_bad = 1'b0;
`endif

   assign wdat_l = wb_dat_i;
   assign rdat_l = rsp_rdata_i;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      wb_bfm_lane u_lane (
         .wb_clk   (wb_clk),
         .wb_rst_n (wb_rst_n),
         .ld_w     (ld_w),
         .ld_r     (ld_r),
         .wdat     (wdat_l[g]),
         .wsel     (wb_sel_i[g]),
         .rdat     (rdat_l[g]),
         .wdata_q  (wdata_l[g]),
         .mask_q   (mask_l[g]),
         .rdata_q  (rdata_l[g])
      );
   end

   assign wdata_o  = wdata_l;
   assign mask_o   = mask_l;
   assign wb_sdt_o = rdata_l;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state    <= S_IDLE;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         op_o     <= 1'b0;
         addr_o   <= '0;
         burst_o  <= 1'b0;
         last_o   <= 1'b0;
         bte_o    <= 2'b00;
         rd_cnt_o <= '0;
         wr_cnt_o <= '0;
      end else begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_REQ;
                  addr_o  <= wb_adr_i;
                  op_o    <= wb_we_i;
                  bte_o   <= wb_bte_i;
                  burst_o <= cti_burst;
                  last_o  <= cti_last;
                  if (wb_we_i) wr_cnt_o <= wr_cnt_o + 32'd1;
                  else         rd_cnt_o <= rd_cnt_o + 32'd1;
               end
            end
            S_REQ: begin
               if (!wb_cyc_i) begin
                  state <= S_IDLE;
               end else if (rsp_any) begin
                  state    <= S_RESP;
                  wb_err_o <= rsp_err_i;
                  wb_ack_o <= ~rsp_err_i;
               end
            end
            S_RESP: begin
               if (!wb_cyc_i || wb_err_o || (wb_ack_o && !burst_o)) begin
                  state <= S_IDLE;
               end else if (adr_bad) begin
                  wb_err_o <= 1'b1;
               end else if (cont) begin
                  state   <= S_REQ;
                  addr_o  <= next_addr;
                  burst_o <= cti_burst;
                  last_o  <= cti_last;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_bfm_slave.sv
// Scoreboard bench for wb_bfm_slave: a driver pushes expected beats/terminations, a monitor checks them.
module tb_wb_bfm_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wb_adr = '0, wb_dat = '0, rsp_rdata = '0;
   logic [3:0]  wb_sel = '0;
   logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
   logic [2:0]  wb_cti = '0;
   logic [1:0]  wb_bte = '0;
   logic        rsp_ack = 1'b0, rsp_err = 1'b0;

   logic [31:0] wb_sdt_o, addr_o, wdata_o, rd_cnt_o, wr_cnt_o;
   logic [3:0]  mask_o;
   logic [1:0]  bte_o;
   logic        wb_ack_o, wb_err_o, wb_rty_o, req_o, op_o, burst_o, last_o;

   always #5 clk = ~clk;

   wb_bfm_slave #(.aw(32), .dw(32)) dut (
      .wb_clk(clk), .wb_rst_n(rst_n),
      .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel), .wb_we_i(wb_we),
      .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_cti_i(wb_cti), .wb_bte_i(wb_bte),
      .wb_sdt_o(wb_sdt_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
      .req_o(req_o), .op_o(op_o), .addr_o(addr_o), .wdata_o(wdata_o), .mask_o(mask_o),
      .burst_o(burst_o), .bte_o(bte_o), .last_o(last_o),
      .rsp_ack_i(rsp_ack), .rsp_err_i(rsp_err), .rsp_rdata_i(rsp_rdata),
      .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o)
   );

   typedef struct {
      logic [31:0] addr;
      logic        op;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        burst;
      logic        last;
   } req_t;

   typedef struct {
      logic        ack;
      logic        err;
      logic [31:0] sdt;
      logic [31:0] rd;
      logic [31:0] wr;
   } term_t;

   req_t  exp_req[$];
   term_t exp_term[$];

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] sdt_m = '0;
   logic [31:0] rd_n = '0, wr_n = '0;
   logic        req_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference address of beat i: linear steps by 4 bytes, wrapping bursts
   // stay inside an aligned window of N beats.
   function automatic logic [31:0] beat_addr(input logic [31:0] st, input logic [1:0] bte, input int i);
      int unsigned span, off;
      if (bte == 2'b00) return st + 32'(i * 4);
      span = (4 << (bte - 2'd1)) * 4;
      off  = st % span;
      return (st - off) + 32'((off + 32'(i * 4)) % span);
   endfunction

   always @(negedge clk) begin
      req_t  er;
      term_t et;
      if (rst_n) begin
         if (req_o && !req_prev) begin
            if (exp_req.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_req: got req_o=1 addr %h expected no beat", addr_o);
            end else begin
               er = exp_req.pop_front();
               chk("addr_o", addr_o, er.addr);
               chk("op_o", 32'(op_o), 32'(er.op));
               if (er.op) chk("wdata_o", wdata_o, er.dat);
               chk("mask_o", 32'(mask_o), 32'(er.sel));
               chk("burst_o", 32'(burst_o), 32'(er.burst));
               chk("last_o", 32'(last_o), 32'(er.last));
            end
         end
         if (wb_ack_o || wb_err_o) begin
            if (exp_term.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_term: got ack=%b err=%b expected none", wb_ack_o, wb_err_o);
            end else begin
               et = exp_term.pop_front();
               chk("wb_ack_o", 32'(wb_ack_o), 32'(et.ack));
               chk("wb_err_o", 32'(wb_err_o), 32'(et.err));
               chk("wb_sdt_o", wb_sdt_o, et.sdt);
               chk("rd_cnt_o", rd_cnt_o, et.rd);
               chk("wr_cnt_o", wr_cnt_o, et.wr);
               chk("wb_rty_o", 32'(wb_rty_o), 32'd0);
            end
         end
      end
      req_prev = req_o;
   end

   task automatic push_term(input logic err);
      term_t t;
      t.ack = ~err; t.err = err; t.sdt = sdt_m; t.rd = rd_n; t.wr = wr_n;
      exp_term.push_back(t);
   endtask

   task automatic end_cycle();
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_cycle(input logic [31:0] start, input logic we, input logic [1:0] bte,
                            input int nb, input int err_beat, input int both_beat,
                            input int drop_beat, input int bad_beat,
                            input logic [31:0] dat0, input logic [3:0] sel0,
                            input logic [31:0] rd0);
      for (int i = 0; i < nb; i++) begin
         logic [31:0] a, r;
         logic [2:0]  cti;
         logic        ok, err;
         int          waitc;
         req_t        q;
         a   = beat_addr(start, bte, i);
         r   = (i == 0) ? rd0 : $urandom;
         cti = (nb == 1) ? 3'b000 : ((i == nb - 1) ? 3'b111 : 3'b010);
         wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_cti = cti; wb_bte = bte;
         wb_dat = (i == 0) ? dat0 : $urandom;
         wb_sel = (i == 0) ? sel0 : 4'($urandom);
`ifdef WB_BFM_SLAVE_ADDR_CHECK_EN
         wb_adr = (i == bad_beat) ? 32'h200 : a;
         if (i == bad_beat) begin
            push_term(1'b1);
            @(posedge clk); #1;
            chk("bad_adr_no_req", 32'(req_o), 32'd0);
            @(posedge clk); #1;
            end_cycle();
            return;
         end
`else
         // continuation addresses are not checked, so drive junk there
         wb_adr = (i == 0) ? a : ((i == bad_beat) ? 32'h200 : $urandom);
`endif
         if (i == 0) begin
            if (we) wr_n++; else rd_n++;
         end
         q.addr = a; q.op = we; q.dat = wb_dat; q.sel = wb_sel;
         q.burst = (cti == 3'b010); q.last = (cti == 3'b000) || (cti == 3'b111);
         exp_req.push_back(q);
         ok = 1'b0;
         for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk); #1;
            ok = req_o;
         end
         chk("req_seen", 32'(ok), 32'd1);
         if (!ok) begin
            end_cycle();
            return;
         end
         if (i == drop_beat) begin
            end_cycle();
            chk("drop_req_low", 32'(req_o), 32'd0);
            return;
         end
         waitc = $urandom_range(0, 2);
         if (waitc != 0) begin
            wb_stb = 1'($urandom_range(0, 1));
            repeat (waitc) begin @(posedge clk); #1; end
            chk("req_held", 32'(req_o), 32'd1);
            wb_stb = 1'b1;
         end
         err = (i == err_beat) || (i == both_beat);
         rsp_ack = (i != err_beat); rsp_err = err; rsp_rdata = r;
         if (!we) sdt_m = r;
         push_term(err);
         @(posedge clk); #1;
         rsp_ack = 1'b0; rsp_err = 1'b0; rsp_rdata = $urandom;
         @(posedge clk); #1;
         if (err || i == nb - 1) begin
            end_cycle();
            return;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      chk("rst_req_o", 32'(req_o), 32'd0);
      chk("rst_ack", 32'(wb_ack_o), 32'd0);
      chk("rst_err", 32'(wb_err_o), 32'd0);
      chk("rst_rty", 32'(wb_rty_o), 32'd0);
      chk("rst_sdt", wb_sdt_o, 32'd0);
      chk("rst_addr", addr_o, 32'd0);
      chk("rst_wdata", wdata_o, 32'd0);
      chk("rst_mask", 32'(mask_o), 32'd0);
      chk("rst_flags", {28'd0, op_o, burst_o, last_o, 1'b0}, 32'd0);
      chk("rst_bte", 32'(bte_o), 32'd0);
      chk("rst_rd_cnt", rd_cnt_o, 32'd0);
      chk("rst_wr_cnt", wr_cnt_o, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_cycle(32'h10, 1'b1, 2'b00, 1, -1, -1, -1, -1, 32'hDEADBEEF, 4'hF, 32'h0);
      run_cycle(32'h20, 1'b0, 2'b00, 1, -1, -1, -1, -1, 32'h0, 4'hF, 32'h12345678);
      run_cycle(32'h100, 1'b1, 2'b00, 4, -1, -1, -1, -1, $urandom, 4'hF, 32'h0);
      run_cycle(32'h108, 1'b0, 2'b01, 4, -1, -1, -1, -1, 32'h0, 4'hF, $urandom);
      run_cycle(32'h300, 1'b0, 2'b00, 4, 1, -1, -1, -1, 32'h0, 4'hF, $urandom);
      run_cycle(32'h40, 1'b0, 2'b00, 1, -1, 0, -1, -1, 32'h0, 4'hF, $urandom);
      run_cycle(32'h50, 1'b1, 2'b00, 1, -1, -1, 0, -1, 32'hCAFEF00D, 4'h3, 32'h0);
      run_cycle(32'h100, 1'b1, 2'b00, 4, -1, -1, -1, 1, $urandom, 4'hF, 32'h0);

      // async reset asserted mid-beat
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h44; wb_cti = 3'b000; wb_bte = 2'b00;
      @(posedge clk); #1;
      chk("mid_rst_req_before", 32'(req_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      rd_n = '0; wr_n = '0; sdt_m = '0;
      chk("mid_rst_req_o", 32'(req_o), 32'd0);
      chk("mid_rst_addr", addr_o, 32'd0);
      chk("mid_rst_rd_cnt", rd_cnt_o, 32'd0);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", 32'(req_o), 32'd0);

      for (int n = 0; n < 40; n++) begin
         int nb, eb, db;
         nb = $urandom_range(1, 6);
         eb = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
         db = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
         run_cycle({$urandom} & 32'hFFFF_FFFC, 1'($urandom), 2'($urandom), nb, eb, -1, db, -1,
                   $urandom, 4'($urandom), $urandom);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("req_queue_drained", exp_req.size(), 32'd0);
      chk("term_queue_drained", exp_term.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_bfm_slave.md
WB_BFM_SLAVE -- requirements
Module: wb_bfm_slave

Interface
REQ-001 Parameter: aw, 32, address width.
REQ-002 Parameter: dw, 32, data width; byte lanes = dw/8.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 wb_clk  in  1  clock; all state changes on its rising edge.
REQ-005 wb_rst_n  in  1  asynchronous active-low reset.
REQ-006 wb_adr_i in aw, wb_dat_i in dw, wb_sel_i in dw/8, wb_we_i in 1: Wishbone request fields.
REQ-007 wb_cyc_i, wb_stb_i in 1; wb_cti_i in 3; wb_bte_i in 2: Wishbone cycle qualifiers.
REQ-008 wb_sdt_o out dw, read data; wb_ack_o, wb_err_o, wb_rty_o out 1, terminations.
REQ-009 req_o out 1: a beat is pending for the user side.
REQ-010 op_o out 1, write flag; addr_o out aw, beat address; wdata_o out dw, write data; mask_o out dw/8, byte mask.
REQ-011 burst_o out 1, burst cycle flag; bte_o out 2, burst type; last_o out 1, this beat ends the cycle.
REQ-012 rsp_ack_i in 1, rsp_err_i in 1, rsp_rdata_i in dw: user-side beat response.
REQ-013 rd_cnt_o out 32 and wr_cnt_o out 32: completed-start counts of read and write cycles.

Function
REQ-014 The FSM has three states: IDLE, REQ and RESP.
REQ-015 IDLE->REQ: on wb_cyc_i&wb_stb_i, latch adr, we, sel, dat, cti, bte; addr_o = wb_adr_i; increment wr_cnt_o if we, else rd_cnt_o.
REQ-016 In REQ, req_o=1 and the latched fields are held stable.
REQ-017 burst_o=1 when cti is 001 or 010; last_o=1 when cti is 000 or 111.
REQ-018 REQ->RESP on rsp_ack_i or rsp_err_i; capture rsp_rdata_i into wb_sdt_o.
REQ-019 In RESP, exactly one of wb_ack_o/wb_err_o is high for one cycle, registered, one cycle after the user response.
REQ-020 If rsp_ack_i and rsp_err_i are high together, err wins.
REQ-021 RESP->IDLE after an ack when the beat was last (not a burst), or after any err.
REQ-022 RESP->REQ after a non-last burst ack, when wb_cyc_i&wb_stb_i hold; relatch dat, sel and cti; addr_o = next address.
REQ-023 Next address, linear (bte 00): addr + dw/8.
REQ-024 Next address, wrap4/8/16 (bte 01/10/11): increment by dw/8 with carry confined to the low log2(N*dw/8) bits.
REQ-025 wb_sdt_o holds its last value outside reads; write beats leave it unchanged.
REQ-026 wb_rty_o is constant 0.
REQ-027 If wb_cyc_i deasserts in REQ or RESP, go to IDLE next cycle; drop req_o; no termination is issued.
REQ-028 A stb low gap inside a burst keeps REQ/RESP waiting; req_o stays asserted.
REQ-029 Counters wrap modulo 2^32.

Reset
REQ-030 Async assert forces: state IDLE; req_o, wb_ack_o, wb_err_o = 0; wb_sdt_o, addr_o, wdata_o, mask_o = 0; counters = 0; all other outputs 0.
REQ-031 Reset deassertion mid-cycle: the slave starts in IDLE and only accepts a new cyc&stb.

Configuration
REQ-032 Macro WB_BFM_SLAVE_ADDR_CHECK_EN.
REQ-033 Defined: each burst beat after the first compares wb_adr_i with the computed address; on mismatch, issue wb_err_o without raising req_o, then go to IDLE.
REQ-034 Undefined: wb_adr_i is ignored after the first beat and no check logic exists.

Verification
REQ-035 Classic write: adr 0x10, dat 0xDEADBEEF, sel 1111, cti 000.
- req_o with op_o=1, addr_o=0x10.
- rsp_ack_i -> one wb_ack_o pulse; wr_cnt_o=1.
REQ-036 Classic read: adr 0x20, rsp_rdata_i 0x12345678 -> wb_sdt_o=0x12345678 with wb_ack_o; rd_cnt_o=1.
REQ-037 Linear burst: 4 beats from 0x100, cti 010,010,010,111 -> addr_o 0x100, 0x104, 0x108, 0x10C; IDLE after the 4th ack.
REQ-038 Wrap4 burst from 0x108 -> addr_o 0x108, 0x10C, 0x100, 0x104.
REQ-039 Error handling:
- rsp_err_i on beat 2 of a burst -> wb_err_o pulse, IDLE.
- rsp_ack_i&rsp_err_i together -> err only.
- cyc drop in REQ -> no ack, IDLE.
REQ-040 With WB_BFM_SLAVE_ADDR_CHECK_EN: beat-2 wb_adr_i 0x200 against expected 0x104 -> wb_err_o, req_o stays low.
